// File: rtl/instr_prefetch_buffer_pkg.sv
// instr_prefetch_buffer_pkg: shared widths and queue entry layout for the prefetch buffer.
package instr_prefetch_buffer_pkg;
    localparam int INSTR_WIDTH = 32;
    localparam logic [INSTR_WIDTH-1:0] RESET_PC_DEFAULT = '0;
    typedef struct packed {
        logic [INSTR_WIDTH-1:0] pc;
        logic [INSTR_WIDTH-1:0] instr;
    } fetch_entry_t;
    localparam int ENTRY_WIDTH = $bits(fetch_entry_t);
endpackage

// File: rtl/instr_prefetch_buffer_fifo.sv
// prefetch_fifo: synchronous FIFO holding tagged instructions; clear empties it in one edge.
module prefetch_fifo
    import instr_prefetch_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = ENTRY_WIDTH
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       clear_i,
    input  logic [WIDTH-1:0]           data_i,
    output logic [WIDTH-1:0]           head_o,
    output logic [$clog2(DEPTH):0]     count_o
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
    logic [AW:0]      count_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_i) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
        end
    end
    always_ff @(posedge clk_i) begin
        if (push_i && !clear_i) mem_q[wr_ptr_q] <= data_i;
    end
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
endmodule

// File: rtl/instr_prefetch_buffer.sv
// instr_prefetch_buffer: credit-based sequential fetcher feeding a PC-tagged queue to IF;
// a redirect flushes the queue and drops every response still in flight.
module instr_prefetch_buffer
    import instr_prefetch_buffer_pkg::*;
#(
    parameter int                     DEPTH    = 4,
    parameter logic [INSTR_WIDTH-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    output logic                   mem_req_valid_o,
    input  logic                   mem_req_ready_i,
    output logic [INSTR_WIDTH-1:0] mem_req_addr_o,
    input  logic                   mem_resp_valid_i,
    input  logic [INSTR_WIDTH-1:0] mem_resp_data_i,
    input  logic                   redirect_valid_i,
    input  logic [INSTR_WIDTH-1:0] redirect_pc_i,
    input  logic                   out_ready_i,
    output logic                   out_valid_o,
    output logic [INSTR_WIDTH-1:0] out_instr_o,
    output logic [INSTR_WIDTH-1:0] out_pc_o
);
    localparam int CW = $clog2(DEPTH) + 1;
    logic [INSTR_WIDTH-1:0] fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
    logic [CW-1:0]          outstanding_q, outstanding_d, drop_cnt_q, drop_cnt_d, count;
    logic                   req_fire, dropping, push, pop;
    fetch_entry_t           head;
    always_comb begin
        out_valid_o     = count != '0;
        out_instr_o     = out_valid_o ? head.instr : '0;
        out_pc_o        = out_valid_o ? head.pc : '0;
        mem_req_valid_o = count + outstanding_q < CW'(DEPTH);
        mem_req_addr_o  = fetch_pc_q;
        req_fire        = mem_req_valid_o & mem_req_ready_i;
        dropping        = drop_cnt_q != '0;
        push            = mem_resp_valid_i & !dropping & !redirect_valid_i;
        pop             = out_valid_o & out_ready_i & !redirect_valid_i;
        outstanding_d   = outstanding_q + CW'(req_fire) - CW'(mem_resp_valid_i);
        // On redirect everything not yet returned by the end of this cycle is stale
        drop_cnt_d      = redirect_valid_i ? outstanding_d : drop_cnt_q - CW'(mem_resp_valid_i & dropping);
        fetch_pc_d      = redirect_valid_i ? redirect_pc_i : fetch_pc_q + (req_fire ? INSTR_WIDTH'(4) : '0);
        resp_pc_d       = redirect_valid_i ? redirect_pc_i : resp_pc_q + (push ? INSTR_WIDTH'(4) : '0);
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end
    prefetch_fifo #(.DEPTH(DEPTH), .WIDTH(ENTRY_WIDTH)) u_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push_i (push),
        .pop_i  (pop),
        .clear_i(redirect_valid_i),
        .data_i ({resp_pc_q, mem_resp_data_i}),
        .head_o (head),
        .count_o(count)
    );
endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// tb_instr_prefetch_buffer: directed checks of streaming, backpressure, redirect, wrap and async reset.
module tb_instr_prefetch_buffer;
    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        mem_req_valid_o;
    logic        mem_req_ready_i = 1'b1;
    logic [31:0] mem_req_addr_o;
    logic        mem_resp_valid_i = 1'b0;
    logic [31:0] mem_resp_data_i = '0;
    logic        redirect_valid_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        out_ready_i = 1'b0;
    logic        out_valid_o;
    logic [31:0] out_instr_o;
    logic [31:0] out_pc_o;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int lat = 1;
    int n_fire = 0;
    logic [31:0] q_addr[$];
    int          q_due[$];

    always #5 clk_i = ~clk_i;

    instr_prefetch_buffer #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_req_addr_o(mem_req_addr_o),
        .mem_resp_valid_i(mem_resp_valid_i), .mem_resp_data_i(mem_resp_data_i),
        .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i),
        .out_ready_i(out_ready_i), .out_valid_o(out_valid_o),
        .out_instr_o(out_instr_o), .out_pc_o(out_pc_o)
    );

    function automatic logic [31:0] img(input logic [31:0] a);
        return a ^ 32'h1300_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives the memory for the current cycle, then advances to the next negedge.
    task automatic cycle();
        mem_resp_valid_i = 1'b0;
        mem_resp_data_i  = '0;
        if (q_due.size() > 0 && q_due[0] == cyc) begin
            mem_resp_valid_i = 1'b1;
            mem_resp_data_i  = img(q_addr[0]);
            void'(q_addr.pop_front());
            void'(q_due.pop_front());
        end
        if (mem_req_valid_o && mem_req_ready_i) begin
            q_addr.push_back(mem_req_addr_o);
            q_due.push_back(cyc + lat);
            n_fire++;
        end
        @(posedge clk_i);
        cyc++;
        @(negedge clk_i);
        redirect_valid_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        redirect_valid_i = 1'b0;
        mem_resp_valid_i = 1'b0;
        mem_resp_data_i = '0;
        mem_req_ready_i = 1'b1;
        out_ready_i = 1'b0;
        q_addr.delete();
        q_due.delete();
        repeat (2) @(negedge clk_i);
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_out_instr", out_instr_o, 0);
        chk("rst_out_pc", out_pc_o, 0);
        rst_ni = 1'b1;
        cyc = 0;
        n_fire = 0;
    endtask

    initial begin
        // Streaming from reset with a one-cycle memory
        lat = 1;
        do_reset();
        out_ready_i = 1'b1;
        chk("t1_req_valid", mem_req_valid_o, 1);
        chk("t1_addr0", mem_req_addr_o, 32'h0);
        cycle();
        chk("t1_addr1", mem_req_addr_o, 32'h4);
        chk("t1_not_yet_valid", out_valid_o, 0);
        cycle();
        chk("t1_addr2", mem_req_addr_o, 32'h8);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t1_valid%0d", i), out_valid_o, 1);
            chk($sformatf("t1_pc%0d", i), out_pc_o, 32'(4 * i));
            chk($sformatf("t1_instr%0d", i), out_instr_o, img(32'(4 * i)));
            cycle();
        end

        // Fill with IF stalled, then drain
        do_reset();
        out_ready_i = 1'b0;
        repeat (4) cycle();
        chk("t2_credit_stop", mem_req_valid_o, 0);
        chk("t2_fires", n_fire, 4);
        repeat (6) cycle();
        chk("t2_still_stopped", mem_req_valid_o, 0);
        chk("t2_fires_after", n_fire, 4);
        chk("t2_full_valid", out_valid_o, 1);
        out_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t2_pop_pc%0d", i), out_pc_o, 32'(4 * i));
            if (i == 1) begin
                chk("t2_resume_valid", mem_req_valid_o, 1);
                chk("t2_resume_addr", mem_req_addr_o, 32'h10);
            end
            cycle();
        end
        chk("t2_next_pc", out_pc_o, 32'h10);
        chk("t2_next_instr", out_instr_o, img(32'h10));

        // Redirect with two responses in flight, three-cycle memory
        lat = 3;
        do_reset();
        out_ready_i = 1'b1;
        cycle();
        cycle();
        mem_req_ready_i = 1'b0;
        redirect_valid_i = 1'b1;
        redirect_pc_i = 32'h100;
        cycle();
        mem_req_ready_i = 1'b1;
        chk("t3_addr", mem_req_addr_o, 32'h100);
        chk("t3_drop2", dut.drop_cnt_q, 2);
        chk("t3_v3", out_valid_o, 0);
        cycle();
        chk("t3_drop1", dut.drop_cnt_q, 1);
        chk("t3_v4", out_valid_o, 0);
        cycle();
        chk("t3_drop0", dut.drop_cnt_q, 0);
        chk("t3_v5", out_valid_o, 0);
        cycle();
        chk("t3_v6", out_valid_o, 0);
        cycle();
        chk("t3_valid", out_valid_o, 1);
        chk("t3_pc", out_pc_o, 32'h100);
        chk("t3_instr", out_instr_o, img(32'h100));
        cycle();
        chk("t3_pc_next", out_pc_o, 32'h104);

        // Redirect coincident with a pop and a response
        lat = 1;
        do_reset();
        out_ready_i = 1'b1;
        repeat (3) cycle();
        chk("t4_head_before", out_pc_o, 32'h4);
        redirect_valid_i = 1'b1;
        redirect_pc_i = 32'h200;
        cycle();
        chk("t4_flushed", out_valid_o, 0);
        chk("t4_addr", mem_req_addr_o, 32'h200);
        chk("t4_drop", dut.drop_cnt_q, 1);
        cycle();
        chk("t4_stale_hidden", out_valid_o, 0);
        cycle();
        chk("t4_valid", out_valid_o, 1);
        chk("t4_pc", out_pc_o, 32'h200);
        chk("t4_instr", out_instr_o, img(32'h200));

        // Address wrap after a redirect near the top of memory
        do_reset();
        out_ready_i = 1'b1;
        redirect_valid_i = 1'b1;
        redirect_pc_i = 32'hFFFF_FFF8;
        cycle();
        chk("t5_addr0", mem_req_addr_o, 32'hFFFF_FFF8);
        chk("t5_empty", out_valid_o, 0);
        cycle();
        chk("t5_addr1", mem_req_addr_o, 32'hFFFF_FFFC);
        cycle();
        chk("t5_pc0", out_pc_o, 32'hFFFF_FFF8);
        cycle();
        chk("t5_pc1", out_pc_o, 32'hFFFF_FFFC);
        cycle();
        chk("t5_pc2", out_pc_o, 32'h0);
        chk("t5_instr2", out_instr_o, img(32'h0));

        // Asynchronous reset with three queued and one outstanding
        do_reset();
        out_ready_i = 1'b0;
        repeat (4) cycle();
        chk("t6_pre_valid", out_valid_o, 1);
        chk("t6_pre_outstanding", dut.outstanding_q, 1);
        chk("t6_pre_drop", dut.drop_cnt_q, 0);
        #2 rst_ni = 1'b0;
        #1;
        chk("t6_async_valid", out_valid_o, 0);
        chk("t6_async_pc", out_pc_o, 0);
        chk("t6_async_credit", mem_req_valid_o, 1);
        do_reset();
        out_ready_i = 1'b1;
        chk("t6_restart_addr", mem_req_addr_o, 32'h0);
        cycle();
        cycle();
        chk("t6_restart_valid", out_valid_o, 1);
        chk("t6_restart_pc", out_pc_o, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
